// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH serial bits (each placed
// according to its own direction strobe) into a word, then hands the word
// to a one-entry holding register with a valid/ready handshake. A word
// that completes while the holding register is full and not being
// consumed is dropped, and the drop is recorded on a sticky overrun flag.

module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     seq_in,
    input  logic                     shift_r,
    input  logic                     shift_l,
    input  logic                     frame_clr_in,
    input  logic                     ready_in,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     valid_out,
    output logic                     overrun_out,
    output logic [$clog2(WIDTH)-1:0] bit_count_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q;
    logic             strobe;
    logic             last_bit;
    logic             word_done;
    logic             take;
    logic             can_load;

    assign strobe    = shift_r | shift_l;
    assign last_bit  = (cnt_q == LAST_BIT);
    // An abort on the same edge swallows the strobe, so no word can complete.
    assign word_done = strobe & last_bit & ~frame_clr_in;
    assign take      = valid_out & ready_in;
    // The holding register can accept a word if it is empty or is being
    // emptied on this very edge.
    assign can_load  = ~valid_out | take;

    // Next assembly value: shift_r (LSB-first) wins when both strobes are high.
    always_comb begin
        // NOTE: default first so every path assigns shifted and no latch is inferred.
        shifted = asm_q;
        if (shift_r) begin
            shifted = {seq_in, asm_q[WIDTH-1:1]};
        end else if (shift_l) begin
            shifted = {asm_q[WIDTH-2:0], seq_in};
        end
    end

    // Assembly register and bit counter; both restart after a completed word.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: sequential state uses non-blocking assignments only.
            asm_q <= '0;
            cnt_q <= '0;
        end else if (frame_clr_in) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else if (strobe) begin
            if (last_bit) begin
                asm_q <= '0;
                cnt_q <= '0;
            end else begin
                asm_q <= shifted;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Holding register and valid flag; the held word is kept after a transfer.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            parallel_out <= '0;
            valid_out    <= 1'b0;
        end else if (word_done && can_load) begin
            parallel_out <= shifted;
            valid_out    <= 1'b1;
        end else if (take) begin
            valid_out    <= 1'b0;
        end
    end

    // Sticky overrun: set when a completed word is dropped, cleared by abort.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overrun_out <= 1'b0;
        end else if (frame_clr_in) begin
            overrun_out <= 1'b0;
        end else if (word_done && !can_load) begin
            overrun_out <= 1'b1;
        end
    end

    assign bit_count_out = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH = 4). A behavioural
// model tracks the received bits as an integer built with plain arithmetic
// and applies the delivery/overrun rules word by word.

module tb_shift_deserializer;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         seq_in = 1'b0;
    logic         shift_r = 1'b0;
    logic         shift_l = 1'b0;
    logic         frame_clr_in = 1'b0;
    logic         ready_in = 1'b0;
    logic [W-1:0] parallel_out;
    logic         valid_out;
    logic         overrun_out;
    logic [1:0]   bit_count_out;

    int compared   = 0;
    int mismatched = 0;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .seq_in        (seq_in),
        .shift_r       (shift_r),
        .shift_l       (shift_l),
        .frame_clr_in  (frame_clr_in),
        .ready_in      (ready_in),
        .parallel_out  (parallel_out),
        .valid_out     (valid_out),
        .overrun_out   (overrun_out),
        .bit_count_out (bit_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    int       m_bits;    // value of the bits received so far in this word
    int       m_cnt;     // how many bits of the current word have arrived
    bit [3:0] m_hold;
    bit       m_valid;
    bit       m_ovr;

    logic [7:0] obs;
    assign obs = {parallel_out, valid_out, overrun_out, bit_count_out};

    function automatic logic [7:0] expected();
        return {m_hold, m_valid, m_ovr, 2'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_bits = 0; m_cnt = 0; m_hold = '0; m_valid = 0; m_ovr = 0;
    endtask

    // Model one clock edge from the inputs currently being driven.
    task automatic model_edge();
        bit consumed;
        int word;
        consumed = m_valid && ready_in;
        if (frame_clr_in) begin
            m_bits = 0; m_cnt = 0; m_ovr = 0;
            if (consumed) m_valid = 0;
        end else if (shift_r || shift_l) begin
            if (shift_r) word = m_bits / 2 + int'(seq_in) * (1 << (W - 1));
            else         word = (m_bits * 2 + int'(seq_in)) % (1 << W);
            if (m_cnt == W - 1) begin
                m_bits = 0; m_cnt = 0;
                if (!m_valid || consumed) begin
                    m_hold = 4'(word); m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else begin
                m_bits = word; m_cnt = m_cnt + 1;
                if (consumed) m_valid = 0;
            end
        end else if (consumed) begin
            m_valid = 0;
        end
    endtask

    // Drive inputs (from a falling edge), take one rising edge, return at
    // the next falling edge where outputs are sampled.
    task automatic step(input bit sr, input bit sl, input bit d,
                        input bit clr, input bit rdy);
        shift_r = sr; shift_l = sl; seq_in = d; frame_clr_in = clr; ready_in = rdy;
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        shift_r = 0; shift_l = 0; seq_in = 0; frame_clr_in = 0; ready_in = 0;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        compared++;
        if (obs !== 8'h00) begin
            $display("FAIL reset_hold: got %h expected %h", obs, 8'h00);
            mismatched++;
        end
        rst_in = 0;
        model_reset();
        // hold a word and leave two bits in the assembler
        step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0);
        compared++;
        if (obs !== expected()) begin
            $display("FAIL pre_reset_state: got %h expected %h", obs, expected());
            mismatched++;
        end
        #2 rst_in = 1;
        #1;
        model_reset();
        compared++;
        if (obs !== 8'h00) begin
            $display("FAIL async_reset: got %h expected %h", obs, 8'h00);
            mismatched++;
        end
        @(negedge clk_in);
        rst_in = 0;
    endtask

    task automatic test_msb_first();
        bit [3:0] bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, bits[i], 0, 0);
            compared++;
            if (obs !== expected()) begin
                $display("FAIL msb_step%0d: got %h expected %h", 3 - i, obs, expected());
                mismatched++;
            end
        end
        compared++;
        if ({parallel_out, valid_out, bit_count_out} !== {4'b1011, 1'b1, 2'd0}) begin
            $display("FAIL msb_word: got %b/%b/%0d expected 1011/1/0",
                     parallel_out, valid_out, bit_count_out);
            mismatched++;
        end
        step(0, 0, 0, 0, 1);
        for (int i = 3; i >= 0; i--) step(1, 0, bits[i], 0, 0);
        compared++;
        if (parallel_out !== 4'b1101 || obs !== expected()) begin
            $display("FAIL lsb_word: got %h expected %h (word 1101)", obs, expected());
            mismatched++;
        end
    endtask

    task automatic test_overrun();
        bit [3:0] a = 4'b1011;
        bit [3:0] b = 4'b0110;
        step(0, 0, 0, 0, 1);
        for (int i = 3; i >= 0; i--) step(0, 1, a[i], 0, 0);
        for (int i = 3; i >= 0; i--) step(0, 1, b[i], 0, 0);
        compared++;
        if (parallel_out !== 4'b1011 || overrun_out !== 1'b1 || obs !== expected()) begin
            $display("FAIL overrun_set: got %h expected %h", obs, expected());
            mismatched++;
        end
        step(0, 0, 0, 0, 1);
        compared++;
        if (valid_out !== 1'b0 || overrun_out !== 1'b1 || obs !== expected()) begin
            $display("FAIL overrun_sticky: got %h expected %h", obs, expected());
            mismatched++;
        end
        step(0, 0, 0, 1, 0);
        compared++;
        if (overrun_out !== 1'b0 || obs !== expected()) begin
            $display("FAIL overrun_clear: got %h expected %h", obs, expected());
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        bit [11:0] stream = 12'hA5F;
        bit [3:0]  words [3];
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, stream[11 - i], 0, 1);
            compared++;
            if (obs !== expected()) begin
                $display("FAIL b2b_edge%0d: got %h expected %h", i + 1, obs, expected());
                mismatched++;
            end
            if ((i + 1) % 4 == 0) begin
                compared++;
                if (valid_out !== 1'b1 || parallel_out !== words[i / 4] || overrun_out !== 1'b0) begin
                    $display("FAIL b2b_word%0d: got %h/%b expected %h/1",
                             i / 4, parallel_out, valid_out, words[i / 4]);
                    mismatched++;
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bit [3:0] c = 4'hC;
        bit [3:0] t = 4'h3;
        step(0, 0, 0, 0, 1);
        for (int i = 3; i >= 0; i--) step(0, 1, t[i], 0, 0);
        for (int i = 3; i >= 0; i--) step(0, 1, c[i], 0, (i == 0));
        compared++;
        if (valid_out !== 1'b1 || parallel_out !== 4'hC || overrun_out !== 1'b0
            || obs !== expected()) begin
            $display("FAIL consume_complete: got %h expected %h", obs, expected());
            mismatched++;
        end
    endtask

    task automatic test_abort();
        bit [3:0] w = 4'b1100;
        bit [3:0] v = 4'b1011;
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        compared++;
        if (bit_count_out !== 2'd0 || obs !== expected()) begin
            $display("FAIL abort_count: got %h expected %h", obs, expected());
            mismatched++;
        end
        for (int i = 3; i >= 0; i--) step(0, 1, w[i], 0, 0);
        compared++;
        if (parallel_out !== 4'b1100 || obs !== expected()) begin
            $display("FAIL abort_word: got %h expected %h", obs, expected());
            mismatched++;
        end
        step(0, 0, 0, 0, 1);
        for (int i = 3; i >= 0; i--) step(1, 1, v[i], 0, 0);
        compared++;
        if (parallel_out !== 4'b1101 || obs !== expected()) begin
            $display("FAIL both_strobes: got %h expected %h", obs, expected());
            mismatched++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            step(sel[0], sel[1], 1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom));
            compared++;
            if (obs !== expected()) begin
                $display("FAIL random_%0d: got %h expected %h", n, obs, expected());
                mismatched++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_in);
        test_reset();
        test_msb_first();
        test_overrun();
        test_back_to_back();
        test_simultaneous();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver for the bit stream produced by the team's 4-bit shift register's `seq_out`. It assembles `WIDTH` serial bits into a word, using per-bit direction strobes. Each completed word goes into a one-entry holding register with a valid/ready handshake. Overflow of the holding register is reported on a sticky overrun flag. It sits between a serial link and a parallel consumer such as a FIFO or register file.

## Interface
- `WIDTH`, default 4: word width in bits. Legal range is 2–32.
- `clk_in` input 1: clock; all logic is on the rising edge.
- `rst_in` input 1: reset, asynchronous and active-high.
- `seq_in` input 1: serial data bit, sampled on a strobe edge.
- `shift_r` input 1: strobe for LSB-first arrival. Assembly is `{seq_in, asm[WIDTH-1:1]}`.
- `shift_l` input 1: strobe for MSB-first arrival. Assembly is `{asm[WIDTH-2:0], seq_in}`.
- `frame_clr_in` input 1: synchronous abort.
  - Discards the partial word and zeroes the bit counter.
  - Clears `overrun_out`.
- `parallel_out` output `WIDTH`: held word.
- `valid_out` output 1: the holding register is full.
- `ready_in` input 1: consumer accepts the word.
- `overrun_out` output 1: sticky flag; a completed word was dropped.
- `bit_count_out` output `$clog2(WIDTH)`: number of bits currently assembled, range 0..`WIDTH`-1.

## Operation
- **Internal state:**
  - assembly register `asm[WIDTH-1:0]`;
  - bit counter `cnt`;
  - holding register, which drives `parallel_out`;
  - `valid_out`;
  - `overrun_out`.
- **Reset values:** `asm`, `cnt`, `parallel_out`, `valid_out` and `overrun_out` are all 0. Reset takes effect immediately and asynchronously, including mid-word and with a word held.
- **Strobe:** a strobe is `shift_r | shift_l`. If both are high, `shift_r` has priority. With no strobe, `asm` and `cnt` hold.
- **Mixed direction:** the direction may change between bits of one word. Each bit is placed according to its own strobe, and no error is raised.
- **Priority per edge:**
  1. `rst_in`.
  2. `frame_clr_in`: `asm` ← 0, `cnt` ← 0, `overrun_out` ← 0. Any strobe on the same edge is discarded. The holding register, `valid_out` and the handshake are unaffected.
  3. Strobe with `cnt` < `WIDTH`-1: `asm` shifts, `cnt` increments.
  4. Strobe with `cnt` = `WIDTH`-1: this completes a word. The completed word is the shifted value including the current bit. `cnt` ← 0 and `asm` ← 0.
     - If `valid_out` = 0, or `valid_out & ready_in` on this edge: holding ← completed word, `valid_out` ← 1.
     - Otherwise: the completed word is dropped, the holding register keeps the old word, and `overrun_out` ← 1.
- **Handshake:**
  - A transfer occurs on an edge where `valid_out & ready_in`.
  - `valid_out` falls after a transfer unless a word completes on the same edge; in that case it stays 1 and `parallel_out` updates.
  - `ready_in` is ignored while `valid_out` = 0.
  - `parallel_out` is stable while `valid_out` = 1 and `ready_in` = 0.
  - `parallel_out` keeps its last value after a transfer; it is not cleared.
- **Overrun:** `overrun_out` stays high until `frame_clr_in` or reset. Later words continue to be received normally.
- **Implementation:** counter, registers and handshake only; no separate FSM encoding is required. The states are effectively ASSEMBLING and FULL, held in `valid_out`.

## Timing
- **Latency:** the strobe carrying the last bit is sampled at edge k. `valid_out` = 1 and `parallel_out` hold the new word from edge k onward, visible in cycle k+1.
- **Throughput:** strobes may arrive on consecutive cycles. With `ready_in` held high, one word is delivered every `WIDTH` strobes with no bubbles and no overrun.
- **`bit_count_out`:** equals `cnt` and updates on the same edge as the strobe.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.
- **Reset release:** the first strobe after `rst_in` deasserts is accepted at the next edge.

## Test plan
All scenarios use `WIDTH` = 4.
1. **Reset:** with a word held and `cnt` = 2, pulse `rst_in` asynchronously between edges. Outputs go to 0 immediately: `valid_out` = 0, `parallel_out` = 0, `bit_count_out` = 0, `overrun_out` = 0.
2. **MSB-first:** `shift_l` on 4 consecutive cycles with `seq_in` = 1,0,1,1 and `ready_in` = 0.
   - After the 4th edge: `parallel_out` = 4'b1011, `valid_out` = 1, `bit_count_out` = 0.
   - Re-run with `shift_r` and the same bits: `parallel_out` = 4'b1101.
3. **Overrun:** with 4'b1011 held and `ready_in` = 0, send 0,1,1,0 via `shift_l`.
   - `parallel_out` stays 4'b1011 and `overrun_out` = 1.
   - Raise `ready_in` for one cycle: `valid_out` = 0, `overrun_out` still 1.
   - Pulse `frame_clr_in`: `overrun_out` = 0.
4. **Back-to-back:** `ready_in` = 1 with 12 consecutive `shift_l` strobes carrying 0xA, 0x5, 0xF.
   - `valid_out` pulses on edges 4, 8 and 12 with the correct words.
   - `overrun_out` = 0.
5. **Simultaneous consume and complete:** word 0x3 is held and `ready_in` = 1 on the edge that completes 0xC. `valid_out` stays 1, `parallel_out` = 0xC, no overrun.
6. **Abort and priority:**
   - After 2 bits, assert `frame_clr_in` together with a strobe. `bit_count_out` = 0 and the bit is discarded.
   - Then send 1,1,0,0 via `shift_l`: the word is 4'b1100.
   - With `shift_r` and `shift_l` both high on every bit, the result equals the `shift_r`-only result.
